// File: rtl/nand_serial_logic_unit.sv
// nand_serial_logic_unit: serial SLICE-bits-per-cycle bitwise OR/AND/NOT/XOR built from 2-input nands
// Ports: clk, rst (async, active-high); in_valid/in_ready + op, a, b accept a command;
// out_valid/out_ready + y hand off the result; busy is high while slices are being computed.
// Optional macro NSLU_FLAGS_EN adds registered flag_zero / flag_ones describing y.
module nand_serial_logic_unit #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             busy
`ifdef NSLU_FLAGS_EN
  ,
  output logic             flag_zero,
  output logic             flag_ones
`endif
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] ra, rb, shadow, shadow_n;
  logic [1:0] rop;
  logic [SLICE-1:0] sa, sb, nab, na, nb, res;
  function automatic logic [SLICE-1:0] nand2(input logic [SLICE-1:0] x, input logic [SLICE-1:0] z);
    return ~(x & z);
  endfunction
  // every bit of the slice is a network of 2-input nands; only the op select is a mux
  always_comb begin
    sa = ra[cnt*SLICE +: SLICE];
    sb = rb[cnt*SLICE +: SLICE];
    nab = nand2(sa, sb);
    na = nand2(sa, sa);
    nb = nand2(sb, sb);
    res = rop == 2'b00 ? nand2(na, nb) :
          rop == 2'b01 ? nand2(nab, nab) :
          rop == 2'b10 ? na :
                         nand2(nand2(sa, nab), nand2(sb, nab));
    shadow_n = shadow;
    shadow_n[cnt*SLICE +: SLICE] = res;
  end
  // slices accumulate in shadow so y only ever shows completed results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      y         <= '0;
      cnt       <= '0;
      ra        <= '0;
      rb        <= '0;
      rop       <= '0;
      shadow    <= '0;
`ifdef NSLU_FLAGS_EN
      flag_zero <= 1'b0;
      flag_ones <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          ra       <= a;
          rb       <= b;
          rop      <= op;
          cnt      <= '0;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          state    <= RUN;
        end
        RUN: begin
          shadow <= shadow_n;
          if (cnt == CW'(NSLICE - 1)) begin
            cnt       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            y         <= shadow_n;
`ifdef NSLU_FLAGS_EN
            flag_zero <= shadow_n == '0;
            flag_ones <= &shadow_n;
`endif
            state     <= DONE;
          end else cnt <= cnt + 1'b1;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nand_serial_logic_unit.sv
// tb_nand_serial_logic_unit: table, random and sequence checks of nand_serial_logic_unit (WIDTH=8, SLICE=2)
module tb_nand_serial_logic_unit;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, busy;
  logic [1:0] op = '0;
  logic [7:0] a = '0, b = '0, y;
`ifdef NSLU_FLAGS_EN
  logic flag_zero, flag_ones;
`endif
  int checks = 0, errors = 0;
  nand_serial_logic_unit #(.WIDTH(8), .SLICE(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .busy(busy)
`ifdef NSLU_FLAGS_EN
    , .flag_zero(flag_zero), .flag_ones(flag_ones)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {logic [1:0] o; logic [7:0] x; logic [7:0] z; logic [7:0] e;} vec_t;
  function automatic logic [7:0] model(input logic [1:0] o, input logic [7:0] x, input logic [7:0] z);
    case (o)
      2'd0: return x | z;
      2'd1: return x & z;
      2'd2: return ~x;
      default: return x ^ z;
    endcase
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic do_cmd(input logic [1:0] o, input logic [7:0] x, input logic [7:0] z, output int lat);
    int n = 0;
    op = o; a = x; b = z; in_valid = 1'b1;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin errors++; $display("FAIL accept_timeout in_ready=0 required=1"); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask
  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("handoff_out_valid", out_valid, 0);
    check("handoff_in_ready", in_ready, 1);
  endtask
  initial begin
    vec_t tbl[6];
    logic [1:0] qo[3];
    logic [7:0] qa[3], qb[3], expq[$];
    int acc_t[$];
    int lat, idx, hand;
    logic acc, hs;
    tbl[0] = '{2'd0, 8'hA5, 8'h0F, 8'hAF};
    tbl[1] = '{2'd1, 8'hA5, 8'h0F, 8'h05};
    tbl[2] = '{2'd3, 8'hA5, 8'h0F, 8'hAA};
    tbl[3] = '{2'd2, 8'hA5, 8'h0F, 8'h5A};
    tbl[4] = '{2'd3, 8'hFF, 8'hFF, 8'h00};
    tbl[5] = '{2'd2, 8'h00, 8'h3C, 8'hFF};
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_y", y, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      do_cmd(tbl[i].o, tbl[i].x, tbl[i].z, lat);
      check("tbl_latency", lat, 4);
      check("tbl_y", y, tbl[i].e);
      handoff();
    end
    for (int i = 0; i < 8; i++) begin
      logic [1:0] o;
      logic [7:0] x, z;
      o = 2'($urandom_range(0, 3)); x = 8'($urandom); z = 8'($urandom);
      do_cmd(o, x, z, lat);
      check("rnd_latency", lat, 4);
      check("rnd_y", y, model(o, x, z));
      handoff();
    end
    do_cmd(2'd0, 8'hA5, 8'h0F, lat);
    check("stall_latency", lat, 4);
    for (int i = 0; i < 5; i++) begin
      op = 2'($urandom_range(0, 3)); a = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
      check("stall_y", y, 8'hAF);
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
    end
    handoff();
    for (int i = 0; i < 3; i++) begin
      qo[i] = 2'($urandom_range(0, 3)); qa[i] = 8'($urandom); qb[i] = 8'($urandom);
    end
    op = qo[0]; a = qa[0]; b = qb[0];
    in_valid = 1'b1; out_ready = 1'b1; idx = 0; hand = 0;
    for (int c = 0; c < 40; c++) begin
      acc = in_valid && in_ready;
      hs = out_valid && out_ready;
      if (hs) begin
        hand++;
        if (expq.size() > 0) check("b2b_y", y, expq.pop_front());
        else begin errors++; $display("FAIL b2b_extra_result y=%0h required=none", y); end
      end
      if (acc) begin expq.push_back(model(op, a, b)); acc_t.push_back(c); end
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 3) begin op = qo[idx]; a = qa[idx]; b = qb[idx]; end
        else in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    check("b2b_accepts", acc_t.size(), 3);
    check("b2b_results", hand, 3);
    for (int i = 1; i < acc_t.size(); i++) check("b2b_spacing", acc_t[i] - acc_t[i-1], 6);
    op = 2'd0; a = 8'h81; b = 8'h18; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("run_busy", busy, 1);
    check("run_in_ready", in_ready, 0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_y", y, 0);
    check("midrst_in_ready", in_ready, 1);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    do_cmd(2'd3, 8'h3C, 8'hF0, lat);
    check("post_rst_latency", lat, 4);
    check("post_rst_y", y, 8'hCC);
    handoff();
`ifdef NSLU_FLAGS_EN
    do_cmd(2'd1, 8'hFF, 8'h00, lat);
    check("flag_and_y", y, 8'h00);
    check("flag_and_zero", flag_zero, 1);
    check("flag_and_ones", flag_ones, 0);
    handoff();
    do_cmd(2'd0, 8'hFF, 8'h00, lat);
    check("flag_or_y", y, 8'hFF);
    check("flag_or_ones", flag_ones, 1);
    check("flag_or_zero", flag_zero, 0);
    handoff();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
